// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit: radix-2 shift-add MULT and restoring DIV, one bit per cycle.
// Optional MDU_EARLY_ZERO_EN skips the iterations when a zero operand fixes the result.
module mdu_iterative #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic             i_op,
   input  logic             i_sign,
   input  logic [WIDTH-1:0] i_data_1,
   input  logic [WIDTH-1:0] i_data_2,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
   state_t state, state_nxt;

   logic               op_q, sign_q, s1_q, s2_q;
   logic [WIDTH-1:0]   a_q, b_q, quo_q, rem_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [CNT_W-1:0]   cnt_q;

   logic               early_zero, last_iter;
   logic [WIDTH-1:0]   mag_1, mag_2;
   logic [WIDTH:0]     mul_sum, div_shift;
   logic               div_ge;
   logic [WIDTH-1:0]   div_diff;
   logic               neg_prod, neg_quo, neg_rem;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix, orig_1;

`ifdef MDU_EARLY_ZERO_EN
   assign early_zero = i_op ? (i_data_2 == '0) : ((i_data_1 == '0) || (i_data_2 == '0));
`else
   assign early_zero = 1'b0;
`endif

   assign mag_1 = (i_sign && i_data_1[WIDTH-1]) ? -i_data_1 : i_data_1;
   assign mag_2 = (i_sign && i_data_2[WIDTH-1]) ? -i_data_2 : i_data_2;

   assign last_iter = (cnt_q == CNT_W'(WIDTH-1));

   // MULT: low half of acc starts as the multiplier and shifts out LSB-first
   assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);

   // DIV: partial remainder always stays below the divisor, so WIDTH bits hold it
   assign div_shift = {rem_q, quo_q[WIDTH-1]};
   assign div_ge    = (div_shift >= {1'b0, b_q});
   assign div_diff  = div_shift[WIDTH-1:0] - b_q;

   assign neg_prod = sign_q && (s1_q ^ s2_q);
   assign neg_quo  = sign_q && (s1_q ^ s2_q);
   assign neg_rem  = sign_q && s1_q;
   assign prod_fix = neg_prod ? -acc_q : acc_q;
   assign quo_fix  = neg_quo ? -quo_q : quo_q;
   assign rem_fix  = neg_rem ? -rem_q : rem_q;
   // Dividend rebuilt from its magnitude; avoids keeping a copy for divide by zero
   assign orig_1   = (sign_q && s1_q) ? -a_q : a_q;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_start) state_nxt = early_zero ? FIX : CALC;
         CALC:    if (last_iter) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         op_q   <= 1'b0;
         sign_q <= 1'b0;
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         quo_q  <= '0;
         rem_q  <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         o_busy <= 1'b0;
         o_done <= 1'b0;
         o_hi   <= '0;
         o_lo   <= '0;
      end else begin
         o_done <= 1'b0;
         case (state)
            IDLE: begin
               if (i_start) begin
                  op_q   <= i_op;
                  sign_q <= i_sign;
                  s1_q   <= i_data_1[WIDTH-1];
                  s2_q   <= i_data_2[WIDTH-1];
                  a_q    <= mag_1;
                  b_q    <= mag_2;
                  quo_q  <= mag_1;
                  rem_q  <= '0;
                  acc_q  <= early_zero ? '0 : {{WIDTH{1'b0}}, mag_2};
                  cnt_q  <= '0;
                  o_busy <= 1'b1;
               end
            end
            CALC: begin
               cnt_q <= cnt_q + 1'b1;
               if (op_q) begin
                  rem_q <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                  quo_q <= {quo_q[WIDTH-2:0], div_ge};
               end else begin
                  acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
               end
            end
            FIX: begin
               o_busy <= 1'b0;
               o_done <= 1'b1;
               if (!op_q) begin
                  o_hi <= prod_fix[2*WIDTH-1:WIDTH];
                  o_lo <= prod_fix[WIDTH-1:0];
               end else if (b_q == '0) begin
                  o_hi <= orig_1;
                  o_lo <= '1;
               end else begin
                  o_hi <= rem_fix;
                  o_lo <= quo_fix;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_iterative.sv
// Randomized self-checking bench for mdu_iterative against a plain-arithmetic model.
// Honors MDU_EARLY_ZERO_EN for expected latency.
module tb_mdu_iterative;
   localparam int W = 32;

   logic          i_clk = 1'b0;
   logic          i_reset, i_start, i_op, i_sign;
   logic [W-1:0]  i_data_1, i_data_2;
   logic          o_busy, o_done;
   logic [W-1:0]  o_hi, o_lo;

   int n_chk  = 0;
   int n_pass = 0;

   mdu_iterative #(.WIDTH(W), .CNT_W(6)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_op(i_op), .i_sign(i_sign),
      .i_data_1(i_data_1), .i_data_2(i_data_2),
      .o_busy(o_busy), .o_done(o_done), .o_hi(o_hi), .o_lo(o_lo)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // {hi, lo} from the arithmetic definition of each operation
   function automatic logic [63:0] model(input logic op, input logic sgn,
                                         input logic [31:0] d1, input logic [31:0] d2);
      logic [63:0] x, y;
      int sd1, sd2;
      if (!op) begin
         x = sgn ? {{32{d1[31]}}, d1} : {32'b0, d1};
         y = sgn ? {{32{d2[31]}}, d2} : {32'b0, d2};
         return x * y;
      end
      if (d2 == 32'd0) return {d1, 32'hFFFF_FFFF};
      if (!sgn) return {d1 % d2, d1 / d2};
      if (d1 == 32'h8000_0000 && d2 == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      sd1 = d1;
      sd2 = d2;
      return {32'(sd1 % sd2), 32'(sd1 / sd2)};
   endfunction

   function automatic int exp_lat(input logic op, input logic [31:0] d1, input logic [31:0] d2);
`ifdef MDU_EARLY_ZERO_EN
      if (op ? (d2 == 0) : (d1 == 0 || d2 == 0)) return 1;
`endif
      return 33;
   endfunction

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // Drive a request, let E0 take it, then scramble inputs to prove they are not resampled
   task automatic start_op(input logic op, input logic sgn, input logic [31:0] d1, input logic [31:0] d2);
      i_op = op; i_sign = sgn; i_data_1 = d1; i_data_2 = d2; i_start = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      i_op = 1'($urandom); i_sign = 1'($urandom); i_data_1 = $urandom; i_data_2 = $urandom;
      chk("busy_after_e0", {63'd0, o_busy}, 64'd1);
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (lat < 200) begin
         @(posedge i_clk); #1;
         lat++;
         if (o_done) break;
      end
   endtask

   task automatic run(input logic op, input logic sgn, input logic [31:0] d1, input logic [31:0] d2);
      int lat;
      logic [63:0] m;
      m = model(op, sgn, d1, d2);
      start_op(op, sgn, d1, d2);
      wait_done(lat);
      chk("latency", 64'(lat), 64'(exp_lat(op, d1, d2)));
      chk("hi", {32'd0, o_hi}, {32'd0, m[63:32]});
      chk("lo", {32'd0, o_lo}, {32'd0, m[31:0]});
      chk("busy_in_done", {63'd0, o_busy}, 64'd0);
      @(posedge i_clk); #1;
      chk("done_drop", {63'd0, o_done}, 64'd0);
      chk("hold_lo", {32'd0, o_lo}, {32'd0, m[31:0]});
   endtask

   initial begin
      int lat, seen;
      logic [63:0] m;
      i_reset = 1'b1; i_start = 1'b0; i_op = 1'b0; i_sign = 1'b0;
      i_data_1 = '0; i_data_2 = '0;
      repeat (3) @(posedge i_clk);
      #1;
      chk("rst_busy", {63'd0, o_busy}, 64'd0);
      chk("rst_done", {63'd0, o_done}, 64'd0);
      chk("rst_hi", {32'd0, o_hi}, 64'd0);
      chk("rst_lo", {32'd0, o_lo}, 64'd0);
      @(negedge i_clk) i_reset = 1'b0;

      run(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("t1_hi", {32'd0, o_hi}, {32'd0, 32'hFFFF_FFFE});
      chk("t1_lo", {32'd0, o_lo}, 64'd1);
      run(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7);
      run(1'b0, 1'b0, 32'hFFFF_FFFD, 32'd7);
      run(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
      chk("t3_lo", {32'd0, o_lo}, {32'd0, 32'hFFFF_FFFD});
      run(1'b1, 1'b0, 32'd100, 32'd7);
      run(1'b1, 1'b0, 32'h1234, 32'd0);
      run(1'b1, 1'b1, 32'hFFFF_1234, 32'd0);
      run(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      run(1'b0, 1'b1, 32'd0, 32'hFFFF_FFFB);
      run(1'b1, 1'b1, 32'h8000_0001, 32'd3);

      for (int i = 0; i < 40; i++)
         run(1'($urandom), 1'($urandom), rnd_val(), rnd_val());

      // Second request mid-operation must be dropped
      m = model(1'b0, 1'b1, 32'h0001_2345, 32'hFFFF_FF00);
      start_op(1'b0, 1'b1, 32'h0001_2345, 32'hFFFF_FF00);
      repeat (9) @(posedge i_clk);
      #1;
      i_op = 1'b1; i_sign = 1'b0; i_data_1 = 32'd77; i_data_2 = 32'd5; i_start = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      wait_done(lat);
      chk("ign_latency", 64'(lat), 64'd23);
      chk("ign_hi", {32'd0, o_hi}, {32'd0, m[63:32]});
      chk("ign_lo", {32'd0, o_lo}, {32'd0, m[31:0]});

      // Back-to-back: start in the o_done cycle
      m = model(1'b0, 1'b0, 32'h0000_ABCD, 32'h0000_1111);
      start_op(1'b0, 1'b0, 32'h0000_ABCD, 32'h0000_1111);
      wait_done(lat);
      chk("b2b_latency", 64'(lat), 64'd33);
      chk("b2b_lo", {32'd0, o_lo}, {32'd0, m[31:0]});

      // Reset mid-division
      start_op(1'b1, 1'b1, 32'h1234_5678, 32'h0000_0013);
      repeat (14) @(posedge i_clk);
      #1;
      i_reset = 1'b1;
      #1;
      chk("mid_rst_busy", {63'd0, o_busy}, 64'd0);
      chk("mid_rst_done", {63'd0, o_done}, 64'd0);
      chk("mid_rst_hi", {32'd0, o_hi}, 64'd0);
      chk("mid_rst_lo", {32'd0, o_lo}, 64'd0);
      @(negedge i_clk) i_reset = 1'b0;
      seen = 0;
      repeat (50) begin
         @(posedge i_clk); #1;
         if (o_done || o_busy) seen++;
      end
      chk("no_activity_after_rst", 64'(seen), 64'd0);
      run(1'b1, 1'b1, 32'h1234_5678, 32'h0000_0013);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
